uart_rx_core: RTL and testbench

- Standalone UART receiver; the receive end of the serial link driven by the team's UART transmitter (tx_out).
- Runs on a single clock at OVERSAMPLE x baud. Recovers 8N1 frames LSB-first and presents bytes through the existing rx_empty/uld_rx_data unload handshake.
- Adds a line synchronizer, false-start rejection, framing and overrun detection.
- Used in loopback benches and as the RX half of future UART variants.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync.sv | 34 +++
 rtl/uart_rx_core.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_e        : receiver FSM states (PARITY only reachable when the
//                       receiver is built with UART_PARITY_EN defined)
//   UART_DATA_BITS    : default data bits per frame
//   UART_OVERSAMPLE   : default rxclk cycles per bit period
//   UART_PARITY_EVEN  : parity-type selector value for even parity
//   UART_PARITY_ODD   : parity-type selector value for odd parity
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// ----------------------------------------------------------------------------
// uart_sync
// STAGES-deep flop chain bringing an asynchronous line into the clk domain.
// All flops reset to 1 so an idle-high serial line shows no edge out of reset.
// Ports:
//   clk     : destination clock
//   rst     : asynchronous active-high reset
//   async_i : asynchronous input
//   sync_o  : synchronized output (STAGES cycles of latency)
// ----------------------------------------------------------------------------
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule : uart_sync

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// Oversampling 8N1 (LSB-first) UART receiver with false-start rejection,
// framing and overrun detection, and an rx_empty/uld_rx_data unload handshake.
// Build option: define UART_PARITY_EN to add a parity bit between data and
// stop (parameter PARITY_ODD selects odd parity); otherwise rx_parity_err is 0.
// Ports:
//   rxclk         : clock, OVERSAMPLE x baud
//   reset         : asynchronous active-high reset
//   rx_enable     : receiver enable; dropping it mid-frame aborts the frame
//   rx_in         : asynchronous serial line, idles high
//   uld_rx_data   : unload strobe, consumes the held byte and clears flags
//   rx_data       : last delivered byte
//   rx_empty      : 1 = no unread byte held
//   rx_busy       : 1 = frame in progress
//   rx_frame_err  : sticky, stop bit sampled 0
//   rx_overrun    : sticky, good frame arrived while a byte was still held
//   rx_parity_err : sticky parity mismatch
// ----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD  = UART_PARITY_EVEN
`endif
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    input  logic                 uld_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_s, rx_s_d_q;
    logic                 stop_done_q, stop_done_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 rx_empty_q, rx_empty_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 cnt_last, cnt_mid, start_edge;
    logic                 good_frame, deliver;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (rxclk),
        .rst     (reset),
        .async_i (rx_in),
        .sync_o  (rx_s)
    );

    assign cnt_last   = (sample_cnt_q == CNT_LAST);
    assign cnt_mid    = (sample_cnt_q == CNT_MID);
    // Edge (not level) detect, so a line stuck low never retriggers.
    assign start_edge = rx_enable && !rx_s && rx_s_d_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_edge) state_d = START;
            START: if (cnt_mid) state_d = rx_s ? IDLE : DATA;  // high at mid start = glitch
            DATA: begin
                if (cnt_last && (bit_cnt_q == BIT_LAST)) begin
`ifdef UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (cnt_last) state_d = STOP;
`endif
            // Leave at mid-stop so the next start edge is caught on time.
            STOP:  if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && !rx_enable) begin
            state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rx_busy      = (state_q != IDLE);
        rx_data      = rx_data_q;
        rx_empty     = rx_empty_q;
        rx_frame_err = frame_err_q;
        rx_overrun   = overrun_q;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        if ((state_q == IDLE) || (state_d != state_q) || cnt_last) begin
            sample_cnt_d = '0;
        end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end

        if (state_q != DATA) begin
            bit_cnt_d = '0;
        end else if (cnt_last) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        shift_d = shift_q;
        if ((state_q == DATA) && cnt_last) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        end

        // Stop bit is captured at mid-stop; the frame is judged one cycle later.
        stop_done_d = (state_q == STOP) && cnt_last && rx_enable;
        stop_bit_d  = stop_done_d ? rx_s : stop_bit_q;

        good_frame = stop_done_q && stop_bit_q;
        deliver    = good_frame && (rx_empty_q || uld_rx_data);

        rx_data_d   = deliver ? shift_q : rx_data_q;
        rx_empty_d  = deliver ? 1'b0 : (uld_rx_data ? 1'b1 : rx_empty_q);

        // Sticky flags: a set in the same cycle as an unload wins.
        if (stop_done_q && !stop_bit_q) begin
            frame_err_d = 1'b1;
        end else if (uld_rx_data) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end

        if (good_frame && !deliver) begin
            overrun_d = 1'b1;
        end else if (uld_rx_data) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rx_s_d_q     <= 1'b1;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            stop_done_q  <= 1'b0;
            stop_bit_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_empty_q   <= 1'b1;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_s_d_q     <= rx_s;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            stop_done_q  <= stop_done_d;
            stop_bit_q   <= stop_bit_d;
            rx_data_q    <= rx_data_d;
            rx_empty_q   <= rx_empty_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic parity_bad;

    // Expected parity bit is the XOR of the data, inverted for odd parity.
    assign parity_bad = (state_q == PARITY) && cnt_last && rx_enable &&
                        (rx_s != ((^shift_q) ^ PARITY_ODD));

    always_comb begin
        if (parity_bad) begin
            parity_err_d = 1'b1;
        end else if (uld_rx_data) begin
            parity_err_d = 1'b0;
        end else begin
            parity_err_d = parity_err_q;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed scenarios against uart_rx_core at default parameters
// (8 data bits, 16x oversampling, 2 synchronizer stages, no parity).
// ----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic       rxclk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_enable = 1'b0;
    logic       rx_in = 1'b1;
    logic       uld_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 rxclk = ~rxclk;

    uart_rx_core dut (
        .rxclk         (rxclk),
        .reset         (reset),
        .rx_enable     (rx_enable),
        .rx_in         (rx_in),
        .uld_rx_data   (uld_rx_data),
        .rx_data       (rx_data),
        .rx_empty      (rx_empty),
        .rx_busy       (rx_busy),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_parity_err (rx_parity_err)
    );

    // Ideal bit-banged frame; call at posedge+1, returns at posedge+1.
    task automatic send_frame(input logic [7:0] data, input logic stop_val);
        rx_in = 1'b0;
        repeat (16) @(posedge rxclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (16) @(posedge rxclk);
            #1;
        end
        rx_in = stop_val;
        repeat (16) @(posedge rxclk);
        #1;
        rx_in = 1'b1;
        repeat (8) @(posedge rxclk);
        #1;
        $display("frame 0x%02h stop=%0b sent: rx_data=0x%02h empty=%0b ferr=%0b ovr=%0b",
                 data, stop_val, rx_data, rx_empty, rx_frame_err, rx_overrun);
    endtask

    // Transmitter model: bits launched on the falling clock edge at 1/16 rate.
    task automatic tx_send(input logic [7:0] data);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge rxclk);
            rx_in = frame[i];
            repeat (15) @(negedge rxclk);
        end
        @(negedge rxclk);
        rx_in = 1'b1;
        repeat (8) @(posedge rxclk);
        #1;
    endtask

    task automatic pulse_uld();
        uld_rx_data = 1'b1;
        @(posedge rxclk);
        #1;
        uld_rx_data = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge rxclk);
        #1;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", rx_empty); else pass_cnt++;
        total_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rx_busy); else pass_cnt++;
        total_cnt++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {rx_frame_err, rx_overrun, rx_parity_err}); else pass_cnt++;
        reset = 1'b0;
        rx_enable = 1'b1;
        repeat (4) @(posedge rxclk);
        #1;
        $display("reset released");
    endtask

    // Exact latency: 153 cycles after the detect edge plus 3 through the synchronizer.
    task automatic test_latency();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int cyc = 1; cyc <= 156; cyc++) begin
                    @(posedge rxclk);
                    #1;
                    if (cyc == 155) begin
                        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL lat_early_empty got=%b exp=1", rx_empty); else pass_cnt++;
                    end
                end
                total_cnt++; if (rx_empty !== 1'b0) $display("FAIL lat_empty got=%b exp=0", rx_empty); else pass_cnt++;
                total_cnt++; if (rx_data !== 8'hA5) $display("FAIL lat_data got=%h exp=a5", rx_data); else pass_cnt++;
            end
        join
        pulse_uld();
        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL lat_uld_empty got=%b exp=1", rx_empty); else pass_cnt++;
    endtask

    task automatic test_loopback();
        int   falls;
        logic prev;
        falls = 0;
        prev  = rx_empty;
        fork
            tx_send(8'h7F);
            begin
                for (int cyc = 0; cyc < 176; cyc++) begin
                    @(posedge rxclk);
                    #1;
                    if (prev && !rx_empty) falls++;
                    prev = rx_empty;
                end
            end
        join
        $display("loopback 0x7f: rx_data=0x%02h empty=%0b falls=%0d", rx_data, rx_empty, falls);
        total_cnt++; if (falls !== 1) $display("FAIL loop_falls got=%0d exp=1", falls); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h7F) $display("FAIL loop_data got=%h exp=7f", rx_data); else pass_cnt++;
        total_cnt++; if ({rx_frame_err, rx_overrun} !== 2'b00)
            $display("FAIL loop_flags got=%b exp=00", {rx_frame_err, rx_overrun}); else pass_cnt++;
        pulse_uld();
        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL loop_uld_empty got=%b exp=1", rx_empty); else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic busy_seen;
        busy_seen = 1'b0;
        rx_in = 1'b0;
        repeat (5) @(posedge rxclk);
        #1;
        rx_in = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge rxclk);
            #1;
            if (rx_busy) busy_seen = 1'b1;
        end
        $display("glitch 5 cycles: busy_seen=%0b busy=%0b empty=%0b", busy_seen, rx_busy, rx_empty);
        total_cnt++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", busy_seen); else pass_cnt++;
        total_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_end got=%b exp=0", rx_busy); else pass_cnt++;
        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL glitch_empty got=%b exp=1", rx_empty); else pass_cnt++;
        total_cnt++; if ({rx_frame_err, rx_overrun} !== 2'b00)
            $display("FAIL glitch_flags got=%b exp=00", {rx_frame_err, rx_overrun}); else pass_cnt++;
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0);
        total_cnt++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_set got=%b exp=1", rx_frame_err); else pass_cnt++;
        total_cnt++; if (rx_empty !== 1'b1) $display("FAIL ferr_empty got=%b exp=1", rx_empty); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h7F) $display("FAIL ferr_data_kept got=%h exp=7f", rx_data); else pass_cnt++;
        send_frame(8'h3C, 1'b1);
        total_cnt++; if (rx_data !== 8'h3C) $display("FAIL ferr_next_data got=%h exp=3c", rx_data); else pass_cnt++;
        total_cnt++; if (rx_empty !== 1'b0) $display("FAIL ferr_next_empty got=%b exp=0", rx_empty); else pass_cnt++;
        total_cnt++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_sticky got=%b exp=1", rx_frame_err); else pass_cnt++;
        pulse_uld();
        total_cnt++; if ({rx_empty, rx_frame_err} !== 2'b10)
            $display("FAIL ferr_uld got=%b exp=10", {rx_empty, rx_frame_err}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        total_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_data got=%h exp=11", rx_data); else pass_cnt++;
        total_cnt++; if (rx_overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", rx_overrun); else pass_cnt++;
        total_cnt++; if (rx_empty !== 1'b0) $display("FAIL ovr_empty got=%b exp=0", rx_empty); else pass_cnt++;
        pulse_uld();
        total_cnt++; if ({rx_empty, rx_overrun} !== 2'b10)
            $display("FAIL ovr_uld got=%b exp=10", {rx_empty, rx_overrun}); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_uld_data got=%h exp=11", rx_data); else pass_cnt++;
    endtask

    task automatic test_enable_abort();
        fork
            send_frame(8'h0F, 1'b1);
            begin
                repeat (50) @(posedge rxclk);
                #1;
                total_cnt++; if (rx_busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", rx_busy); else pass_cnt++;
                rx_enable = 1'b0;
                @(posedge rxclk);
                #1;
                total_cnt++; if (rx_busy !== 1'b0) $display("FAIL abort_busy_after got=%b exp=0", rx_busy); else pass_cnt++;
            end
        join
        rx_enable = 1'b1;
        repeat (4) @(posedge rxclk);
        #1;
        total_cnt++; if ({rx_empty, rx_frame_err, rx_overrun} !== 3'b100)
            $display("FAIL abort_state got=%b exp=100", {rx_empty, rx_frame_err, rx_overrun}); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h11) $display("FAIL abort_data got=%h exp=11", rx_data); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (85) @(posedge rxclk);
                #1;
                total_cnt++; if (rx_busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", rx_busy); else pass_cnt++;
                #1;
                reset = 1'b1;
                #1;
                total_cnt++; if (rx_data !== 8'h00) $display("FAIL midrst_data got=%h exp=00", rx_data); else pass_cnt++;
                total_cnt++; if ({rx_empty, rx_busy, rx_frame_err, rx_overrun, rx_parity_err} !== 5'b10000)
                    $display("FAIL midrst_outs got=%b exp=10000",
                             {rx_empty, rx_busy, rx_frame_err, rx_overrun, rx_parity_err}); else pass_cnt++;
                repeat (5) @(posedge rxclk);
                #1;
                reset = 1'b0;
            end
        join
        send_frame(8'h0F, 1'b1);
        total_cnt++; if (rx_data !== 8'h0F) $display("FAIL midrst_next_data got=%h exp=0f", rx_data); else pass_cnt++;
        total_cnt++; if ({rx_empty, rx_frame_err, rx_overrun} !== 3'b000)
            $display("FAIL midrst_next_state got=%b exp=000", {rx_empty, rx_frame_err, rx_overrun}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_loopback();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_enable_abort();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_uart_rx_core
